// File: rtl/logic_pipe_unit.sv
// Two-stage streaming logic unit: bitwise NOT/AND/OR/XOR and logical LNOT/LAND/LOR/ZTEST on W-bit operands.
// Optional accumulator built only when LOGIC_PIPE_ACC_EN is defined; otherwise out_acc is tied to zero.
module logic_pipe_unit #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_acc,
    input  logic         in_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_bool,
    output logic [W-1:0] out_acc
);

    // Logical opcodes return their single result bit in bit 0, zero-extended to W.
    function automatic logic [W-1:0] logic_eval(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] r;
        logic         a_nz;
        logic         b_nz;
        r    = '0;
        a_nz = |a;
        b_nz = |b;
        case (op)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r[0] = ~a_nz;
            3'd5:    r[0] = a_nz & b_nz;
            3'd6:    r[0] = a_nz | b_nz;
            3'd7:    r[0] = ~a_nz & ~b_nz;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic         s1_valid_r;
    logic [2:0]   s1_op_r;
    logic [W-1:0] s1_a_r;
    logic [W-1:0] s1_b_r;
    logic         s2_valid_r;
    logic [W-1:0] s2_data_r;
    logic         s2_bool_r;
    logic         s2_load_s;
    logic         xfer_s;
    logic [W-1:0] eff_b_s;
    logic [W-1:0] result_s;

    assign s2_load_s = !s2_valid_r || out_ready;
    assign xfer_s    = s1_valid_r && s2_load_s;
    assign in_ready  = !s1_valid_r || s2_load_s;
    assign result_s  = logic_eval(s1_op_r, s1_a_r, eff_b_s);

`ifdef LOGIC_PIPE_ACC_EN
    logic         s1_acc_r;
    logic         s1_clr_r;
    logic [W-1:0] acc_r;

    // Effective operand B: accumulator (or zero when clearing) in acc mode, else the captured b.
    always_comb begin
        eff_b_s = s1_b_r;
        if (s1_acc_r) begin
            if (s1_clr_r) begin
                eff_b_s = '0;
            end else begin
                eff_b_s = acc_r;
            end
        end else begin
            eff_b_s = s1_b_r;
        end
    end

    // Accumulator is read and written on the same S1->S2 transfer, so chained acc ops see no hazard.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r <= '0;
        end else if (xfer_s) begin
            if (s1_acc_r) begin
                acc_r <= result_s;
            end else if (s1_clr_r) begin
                acc_r <= '0;
            end else begin
                acc_r <= acc_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // S1 mode flags travel alongside the operands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_acc_r <= 1'b0;
            s1_clr_r <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_acc_r <= in_acc;
            s1_clr_r <= in_clr;
        end else begin
            s1_acc_r <= s1_acc_r;
            s1_clr_r <= s1_clr_r;
        end
    end

    assign out_acc = acc_r;
`else
    logic unused_mode_s;

    assign unused_mode_s = in_acc ^ in_clr;
    assign eff_b_s       = s1_b_r;
    assign out_acc       = '0;
`endif

    // S1 input register: refills whenever it is empty or draining into S2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r <= in_op;
                s1_a_r  <= in_a;
                s1_b_r  <= in_b;
            end else begin
                s1_op_r <= s1_op_r;
                s1_a_r  <= s1_a_r;
                s1_b_r  <= s1_b_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_op_r    <= s1_op_r;
            s1_a_r     <= s1_a_r;
            s1_b_r     <= s1_b_r;
        end
    end

    // S2 output register: data/bool only change on a transfer so they hold during a stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_bool_r  <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= result_s;
                s2_bool_r <= |result_s;
            end else begin
                s2_data_r <= s2_data_r;
                s2_bool_r <= s2_bool_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_data_r  <= s2_data_r;
            s2_bool_r  <= s2_bool_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_data  = s2_data_r;
    assign out_bool  = s2_bool_r;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed bench for logic_pipe_unit with an expected-result queue drained by an output monitor.
// Covers the LOGIC_PIPE_ACC_EN build when the macro is defined, the accumulator-less build otherwise.
module tb_logic_pipe_unit;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] acc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_acc = 1'b0;
    logic       in_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_bool;
    logic [7:0] out_acc;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic_pipe_unit #(.W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_clr(in_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bool(out_bool), .out_acc(out_acc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one transaction and wait (bounded) for its handshake edge; returns at edge+1.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic clr,
                        input logic [7:0] exp_d, input logic [7:0] exp_acc);
        int n;
        exp_t e;
        e.data = exp_d;
        e.acc  = exp_acc;
        sb_q.push_back(e);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; in_clr = clr;
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: compare each output handshake against the queue head; flag unexpected outputs.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {24'd0, out_data}, 32'hDEAD);
            end else if (out_ready) begin
                e = sb_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e.data});
                chk("out_bool", {31'd0, out_bool}, {31'd0, (e.data != 8'h00)});
                chk("out_acc",  {24'd0, out_acc},  {24'd0, e.acc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_bool", {31'd0, out_bool}, 32'd0);
        chk("rst_out_acc", {24'd0, out_acc}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Latency: handshake at edge N, out_valid after N+1
        send(3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00);
        chk("lat_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {24'd0, out_data}, 32'h30);
        repeat (2) @(posedge clock);
        #1;

        // Back-to-back bitwise ops
        send(3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00);
        send(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hCC, 8'h00);
        send(3'd0, 8'h5A, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00);
        send(3'd2, 8'h0F, 8'h30, 1'b0, 1'b0, 8'h3F, 8'h00);

        // Logical ops, including all-zero and single-bit boundaries
        send(3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00);
        send(3'd5, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        send(3'd6, 8'h00, 8'h80, 1'b0, 1'b0, 8'h01, 8'h00);
        send(3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00);
        send(3'd4, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        send(3'd5, 8'h02, 8'h04, 1'b0, 1'b0, 8'h01, 8'h00);
        send(3'd6, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        send(3'd7, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        send(3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        send(3'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

`ifdef LOGIC_PIPE_ACC_EN
        // Accumulator chain
        send(3'd2, 8'h0F, 8'h99, 1'b1, 1'b1, 8'h0F, 8'h0F);
        send(3'd3, 8'hFF, 8'h99, 1'b1, 1'b0, 8'hF0, 8'hF0);
        send(3'd1, 8'h55, 8'hAA, 1'b0, 1'b1, 8'h00, 8'h00);
`else
        // Without the accumulator, in_acc is ignored and b is used directly
        send(3'd1, 8'hFF, 8'h0F, 1'b1, 1'b0, 8'h0F, 8'h00);
        send(3'd2, 8'h00, 8'h81, 1'b1, 1'b1, 8'h81, 8'h00);
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("drain_empty", sb_q.size(), 32'd0);

        // Backpressure: two accepted, third stalls, output holds
        out_ready = 1'b0;
        send(3'd0, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 8'h00);
        send(3'd3, 8'hAA, 8'hFF, 1'b0, 1'b0, 8'h55, 8'h00);
        sb_q.push_back('{data: 8'h81, acc: 8'h00});
        in_valid = 1'b1; in_op = 3'd1; in_a = 8'hFF; in_b = 8'h81; in_acc = 1'b0; in_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, 32'hF0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("bp_all_delivered", sb_q.size(), 32'd0);

        // Reset mid-flight with a non-zero accumulator
`ifdef LOGIC_PIPE_ACC_EN
        send(3'd2, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h5A);
`else
        send(3'd2, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h00);
`endif
        repeat (2) @(posedge clock);
        #1;
        out_ready = 1'b0;
`ifdef LOGIC_PIPE_ACC_EN
        send(3'd3, 8'h33, 8'h00, 1'b0, 1'b0, 8'h33, 8'h5A);
        send(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h5A);
        chk("pre_rst_acc", {24'd0, out_acc}, 32'h5A);
`else
        send(3'd3, 8'h33, 8'h00, 1'b0, 1'b0, 8'h33, 8'h00);
        send(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00);
`endif
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_acc", {24'd0, out_acc}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clock);
        #1;
        send(3'd2, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 8'h00);
        repeat (3) @(posedge clock);
        #1;
        chk("final_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_pipe_unit.md
# logic_pipe_unit

Parametrised, pipelined logic unit for W-bit operands. It executes bitwise operations (NOT, AND, OR, XOR) and logical operations (LNOT, LAND, LOR, zero-test). Operands arrive on a valid/ready input stream and results leave on a valid/ready output stream. An optional accumulator lets a chain of operations fold into a persistent W-bit register. It is the streaming, width-generic successor of the fixed-width combinational logic-operator test block and sits as a leaf datapath unit behind a producer/consumer handshake.

## Interface
- W, 8, operand/result width; legal for W >= 1.
- clock  in  1  single clock, all state rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  3  opcode; see Operation.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_acc  in  1  use the accumulator as operand B and write the result back to it.
- in_clr  in  1  zero the accumulator for this transaction.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  result.
- out_bool  out  1  out_data != 0.
- out_acc  out  W  current accumulator value.

## Operation
- Opcodes, where B is the effective operand B:
  - 0: ~A.
  - 1: A & B.
  - 2: A | B.
  - 3: A ^ B.
  - 4: LNOT, {0…, A==0}.
  - 5: LAND, {0…, (A!=0)&&(B!=0)}.
  - 6: LOR, {0…, (A!=0)||(B!=0)}.
  - 7: ZTEST, {0…, (A==0)&&(B==0)}.
- Logical results are zero-extended to W, with the result bit in bit 0.
- Two stages:
  - S1 captures {op, a, b, acc, clr} on an in_valid && in_ready handshake.
  - S2 is the output register. The result is computed combinationally from S1 at the moment it transfers into S2.
- Effective B:
  - If acc=1: the value 0 when clr=1, otherwise the accumulator.
  - If acc=0: b.
- Accumulator update, performed on the S1→S2 transfer:
  - acc=1: the accumulator takes the result.
  - acc=0 with clr=1: the accumulator is set to 0.
  - Otherwise the accumulator is unchanged.
- Because the accumulator is read and written at the same transfer, back-to-back acc transactions see each other's results with no hazard.
- Flow control:
  - S2 may load when it is empty or when out_ready=1.
  - S1 advances whenever S2 may load.
  - in_ready = !s1_valid || S2 may load.
- Reset values:
  - out_valid=0, in_ready=1 (combinationally, once reset deasserts), out_data=0, out_bool=0, out_acc=0.
  - S1 is empty.
- out_data, out_bool and out_acc change only on a transfer. They hold while out_valid && !out_ready.
- Undriven behaviour: none. Operands are ignored while in_valid=0.

## Timing
- Latency: 2 cycles. A handshake at edge N makes out_valid=1 after edge N+1.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, S2 holds. S1 fills once, then in_ready falls.
- Release: on the cycle out_ready returns to 1, S2 takes S1 and in_ready=1 in that same cycle. No bubble, no loss, no duplication.
- Simultaneous out-handshake and in-handshake on a full pipe: both complete. S1 is replaced, S2 is replaced.
- Reset mid-operation: all in-flight transactions are dropped and the accumulator is 0 immediately. There is no output pulse after reset.
- in_ready has a combinational dependency on out_ready. There is no combinational path from in_* to out_*.

## Configuration
- LOGIC_PIPE_ACC_EN:
  - Defined: the accumulator behaves as described above.
  - Undefined: no accumulator register is built. in_acc and in_clr are ignored and effective B is always in_b. out_acc is tied to 0. Ports remain so the interface is stable.

## Test plan
- W=8, out_ready=1. Send op1 a=0xF0 b=0x3C, then op3 a=0xF0 b=0x3C, back-to-back → out_data=0x30 at cycle 2, then 0xCC at cycle 3, with out_bool=1 for both.
- W=8. Send op4 a=0x00, then op5 a=0x01 b=0x00, then op6 a=0x00 b=0x80, then op7 a=0 b=0 → out_data 0x01, 0x00, 0x01, 0x01 on consecutive cycles; out_bool 1, 0, 1, 1.
- Accumulator (LOGIC_PIPE_ACC_EN defined). Send op2 acc=1 clr=1 a=0x0F, then op3 acc=1 a=0xFF, then op1 acc=0 clr=1 a=0x55 b=0xAA → out_acc 0x0F, then 0xF0, then 0x00; out_data 0x0F, 0xF0, 0x00.
- Backpressure: hold out_ready=0 and issue 3 transactions → only 2 are accepted, in_ready=0, and out_data is stable. Raise out_ready for 3 cycles → 3 results appear in order and none are lost.
- Reset: assert reset asynchronously between edges while 2 transactions are in flight and acc=0x5A → out_valid, out_acc and out_data read 0 before the next edge. After release, in_ready=1 and no stale results appear.
- LOGIC_PIPE_ACC_EN undefined: send op1 acc=1 a=0xFF b=0x0F → out_data=0x0F and out_acc=0 throughout.
